imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the decode stage. Takes a full 32-bit instruction

---
 rtl/imm_gen_pkg.sv | 87 ++++++++
 rtl/imm_gen_pipe_if.sv | 36 +++
 rtl/imm_extract.sv | 51 +++++
 rtl/imm_gen_pipe.sv | 125 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared types and constants for the registered immediate generator.
//   - imm_fmt_e    : resolved immediate format (value is what out_fmt reports)
//   - skid_state_e : occupancy of the main register + skid slot
//   - imm_entry_t  : max-width view of one buffered entry {imm, fmt, tag}
//   - *_HI/*_LO    : instruction bit positions of every immediate field
//   - resolve_fmt  : maps the 3-bit select onto the format actually used
// Optional feature macro: ZICSR_IMM_EN (select 101 yields the CSR uimm format).
// -----------------------------------------------------------------------------
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_B = 3'd1,
    FMT_U = 3'd2,
    FMT_J = 3'd3,
    FMT_S = 3'd4,
    FMT_Z = 3'd5
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Widest legal XLEN / sideband; modules keep width-fitted copies of this.
  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

  // Sign bit shared by every signed format.
  localparam int SIGN_BIT = 31;
  // I: inst[31:20]
  localparam int I_HI = 31;
  localparam int I_LO = 20;
  // S: {inst[31:25], inst[11:7]}
  localparam int S_HI_HI = 31;
  localparam int S_HI_LO = 25;
  localparam int S_LO_HI = 11;
  localparam int S_LO_LO = 7;
  // B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  localparam int B_B11    = 7;
  localparam int B_MID_HI = 30;
  localparam int B_MID_LO = 25;
  localparam int B_LO_HI  = 11;
  localparam int B_LO_LO  = 8;
  // U: {inst[31:12], 12'b0}
  localparam int U_HI = 31;
  localparam int U_LO = 12;
  // J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  localparam int J_HI_HI = 19;
  localparam int J_HI_LO = 12;
  localparam int J_B11   = 20;
  localparam int J_LO_HI = 30;
  localparam int J_LO_LO = 21;
  // Z: inst[19:15] (CSR uimm, zero-extended)
  localparam int Z_HI = 19;
  localparam int Z_LO = 15;

  // Unused and reserved selects fall back to I; 101 only means Z when CSR
  // immediates are built in.
  function automatic imm_fmt_e resolve_fmt(input logic [2:0] sel);
    imm_fmt_e fmt;
    case (sel)
      3'b000:  fmt = FMT_I;
      3'b001:  fmt = FMT_B;
      3'b010:  fmt = FMT_U;
      3'b011:  fmt = FMT_J;
      3'b100:  fmt = FMT_S;
`ifdef ZICSR_IMM_EN
      3'b101:  fmt = FMT_Z;
`else
      3'b101:  fmt = FMT_I;
`endif
      default: fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Valid/ready bus of the immediate generator: instruction side (in_*) and
// immediate side (out_*).
//   slave  : the generator's view (consumes in_*, produces out_*)
//   master : the surrounding decode logic's view
// Parameters XLEN / TAG_W must match the generator instance.
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_inst, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport master (
    output in_valid, in_inst, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

endinterface

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Combinational immediate extraction for the RISC-V I/S/B/U/J (and optional
// CSR Z) layouts, extended to XLEN.
//   inst_i [31:0]     instruction (opcode bits [6:0] are not looked at)
//   sel_i  [2:0]      requested format select
//   imm_o  [XLEN-1:0] extended immediate
//   fmt_o             format actually used after remapping
// Optional feature macro: ZICSR_IMM_EN (Z extraction only exists when defined).
// -----------------------------------------------------------------------------
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [2:0]      sel_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o
);

  logic [31:0] raw_s;
  logic        unused_opcode_s;

  assign unused_opcode_s = ^inst_i[6:0];

  // Build a 32-bit sign-correct immediate, then widen it to XLEN.
  always_comb begin
    fmt_o = resolve_fmt(sel_i);
    raw_s = 32'd0;
    case (fmt_o)
      FMT_I: raw_s = {{20{inst_i[SIGN_BIT]}}, inst_i[I_HI:I_LO]};
      FMT_S: raw_s = {{20{inst_i[SIGN_BIT]}}, inst_i[S_HI_HI:S_HI_LO],
                      inst_i[S_LO_HI:S_LO_LO]};
      FMT_B: raw_s = {{19{inst_i[SIGN_BIT]}}, inst_i[SIGN_BIT], inst_i[B_B11],
                      inst_i[B_MID_HI:B_MID_LO], inst_i[B_LO_HI:B_LO_LO], 1'b0};
      FMT_U: raw_s = {inst_i[U_HI:U_LO], 12'd0};
      FMT_J: raw_s = {{11{inst_i[SIGN_BIT]}}, inst_i[SIGN_BIT],
                      inst_i[J_HI_HI:J_HI_LO], inst_i[J_B11],
                      inst_i[J_LO_HI:J_LO_LO], 1'b0};
`ifdef ZICSR_IMM_EN
      // Top bit is zero, so the common sign-extension below zero-extends it.
      FMT_Z: raw_s = {27'd0, inst_i[Z_HI:Z_LO]};
`endif
      default: raw_s = {{20{inst_i[SIGN_BIT]}}, inst_i[I_HI:I_LO]};
    endcase
    // U also sign-extends from bit 31 at XLEN=64.
    imm_o = XLEN'($signed(raw_s));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator for the decode stage: one-cycle latency,
// valid/ready on both sides, a main output register backed by one skid slot,
// synchronous flush.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, discards all entries
//   flush  synchronous, drops every held entry and any beat offered with it
//   bus    imm_gen_pipe_if.slave:
//            in_valid/in_ready/in_inst/in_sel/in_tag   instruction side
//            out_valid/out_ready/out_imm/out_fmt/out_tag immediate side
// in_ready is a register (low only when both slots are full), so there is no
// combinational path from out_ready to in_ready.
// Optional feature macro: ZICSR_IMM_EN (select 101 -> CSR uimm, out_fmt=101).
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  skid_state_e     state_q;
  entry_t          main_q;
  entry_t          skid_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [XLEN-1:0] ext_imm_s;
  imm_fmt_e        ext_fmt_s;
  entry_t          new_s;
  logic            accept_s;
  logic            drain_s;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst_i(bus.in_inst),
    .sel_i (bus.in_sel),
    .imm_o (ext_imm_s),
    .fmt_o (ext_fmt_s)
  );

  assign new_s    = '{imm: ext_imm_s, fmt: ext_fmt_s, tag: bus.in_tag};
  assign accept_s = bus.in_valid && in_ready_q;
  assign drain_s  = out_valid_q && bus.out_ready;

  // Occupancy FSM with the main register, skid slot and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Entry contents are left as-is; out_valid=0 marks them dead.
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_q      <= new_s;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end else begin
            state_q     <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            // Pass-through: the new entry replaces the draining one, no bubble.
            main_q      <= new_s;
            state_q     <= ST_ONE;
          end else if (accept_s) begin
            skid_q      <= new_s;
            in_ready_q  <= 1'b0;
            state_q     <= ST_FULL;
          end else if (drain_s) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end else begin
            state_q     <= ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen; the skid entry
          // is older than anything upstream and moves up first.
          if (drain_s) begin
            main_q      <= skid_q;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ONE;
          end else begin
            state_q     <= ST_FULL;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = main_q.imm;
  assign bus.out_fmt   = main_q.fmt;
  assign bus.out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Bench for imm_gen_pipe: an XLEN=32 instance checked every cycle against a
// queue-based model, plus an XLEN=64 instance for wide sign extension.
// Honours ZICSR_IMM_EN in its expectations.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_fmt(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return sel;
`ifdef ZICSR_IMM_EN
      3'd5: return 3'd5;
`endif
      default: return 3'd0;
    endcase
  endfunction

  // Arithmetic form of the field layouts, always computed at 64 bits.
  function automatic logic [63:0] model_imm(input logic [31:0] inst, input logic [2:0] sel);
    longint      si;
    logic [63:0] u;
    logic [63:0] sgn;
    si  = longint'($signed(inst));
    u   = {32'd0, inst};
    sgn = 64'(si >>> 31);
    case (model_fmt(sel))
      3'd1: return (sgn << 12) | (((u >> 7) & 64'd1) << 11) |
                   (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1);
      3'd2: return 64'(si) & ~64'hFFF;
      3'd3: return (sgn << 20) | (((u >> 12) & 64'd255) << 12) |
                   (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1);
      3'd4: return (64'(si >>> 25) << 5) | ((u >> 7) & 64'd31);
      3'd5: return (u >> 15) & 64'd31;
      default: return 64'(si >>> 20);
    endcase
  endfunction

  imm_entry_t mq[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Model update: pop on drain, push on accept (ready while fewer than 2 held).
  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = bus32.in_valid && (mq.size() < 2);
      if (mq.size() > 0 && bus32.out_ready) void'(mq.pop_front());
      if (acc) mq.push_back('{imm: model_imm(bus32.in_inst, bus32.in_sel),
                              fmt: imm_fmt_e'(model_fmt(bus32.in_sel)),
                              tag: 64'(bus32.in_tag)});
    end
  end

  // Every-cycle comparison of the 32-bit instance against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(bus32.in_ready), 64'(mq.size() < 2));
      chk("out_valid", 64'(bus32.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_imm", 64'(bus32.out_imm), {32'd0, mq[0].imm[31:0]});
        chk("out_fmt", 64'(bus32.out_fmt), 64'(mq[0].fmt));
        chk("out_tag", 64'(bus32.out_tag), mq[0].tag);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Offer one beat and hold it until the model says it was taken.
  task automatic send(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] tag);
    bit acc;
    bus32.in_valid = 1'b1;
    bus32.in_inst  = inst;
    bus32.in_sel   = sel;
    bus32.in_tag   = tag;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = (mq.size() < 2);
      @(posedge clk);
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    bus32.in_valid = 1'b0;
  endtask

  // Pin the model with a literal, then check the DUT one cycle after accept.
  task automatic directed(input string name, input logic [31:0] inst, input logic [2:0] sel,
                          input logic [31:0] tag, input logic [31:0] exp_imm,
                          input logic [2:0] exp_fmt);
    logic [63:0] m;
    m = model_imm(inst, sel);
    chk({name, "_model"}, {32'd0, m[31:0]}, {32'd0, exp_imm});
    bus32.out_ready = 1'b1;
    idle(2);
    send(inst, sel, tag);
    chk({name, "_valid"}, 64'(bus32.out_valid), 64'd1);
    chk({name, "_imm"}, 64'(bus32.out_imm), {32'd0, exp_imm});
    chk({name, "_fmt"}, 64'(bus32.out_fmt), 64'(exp_fmt));
    chk({name, "_tag"}, 64'(bus32.out_tag), 64'(tag));
  endtask

  logic [31:0] vec_inst [8] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123450B7,
                                32'hFF9FF06F, 32'h340F9073, 32'h80000013, 32'h7FF0A0E3};
  logic [2:0]  vec_sel  [8] = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1};

  initial begin
    bus32.in_valid = 1'b0; bus32.in_inst = 32'd0; bus32.in_sel = 3'd0;
    bus32.in_tag = 32'd0;  bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_inst = 32'd0; bus64.in_sel = 3'd0;
    bus64.in_tag = 32'd0;  bus64.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_out_imm", 64'(bus32.out_imm), 64'd0);
    chk("rst_out_fmt", 64'(bus32.out_fmt), 64'd0);
    chk("rst_out_tag", 64'(bus32.out_tag), 64'd0);
    chk("rst64_out_imm", bus64.out_imm, 64'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);

    // Formats
    directed("I", 32'hFFF00093, 3'b000, 32'hA1, 32'hFFFF_FFFF, 3'b000);
    directed("S", 32'h0020A423, 3'b100, 32'hA2, 32'h0000_0008, 3'b100);
    directed("B", 32'hFE000EE3, 3'b001, 32'hA3, 32'hFFFF_FFFC, 3'b001);
    directed("U", 32'h123450B7, 3'b010, 32'hA4, 32'h1234_5000, 3'b010);
    directed("J", 32'hFF9FF06F, 3'b011, 32'hA5, 32'hFFFF_FFF8, 3'b011);
    directed("SEL7", 32'h80000013, 3'b111, 32'hA6, 32'hFFFF_F800, 3'b000);
`ifdef ZICSR_IMM_EN
    directed("Z", 32'h340F9073, 3'b101, 32'hA7, 32'h0000_001F, 3'b101);
`else
    directed("Z_as_I", 32'h340F9073, 3'b101, 32'hA7, 32'h0000_0340, 3'b000);
`endif
    idle(2);

    // Backpressure: two accepted, third stalls, FIFO drain without bubble
    bus32.out_ready = 1'b0;
    send(32'h00100093, 3'd0, 32'd1);
    send(32'h00200093, 3'd0, 32'd2);
    chk("bp_in_ready_low", 64'(bus32.in_ready), 64'd0);
    bus32.in_valid = 1'b1; bus32.in_inst = 32'h00300093; bus32.in_sel = 3'd0;
    bus32.in_tag = 32'd3;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("bp_hold_tag", 64'(bus32.out_tag), 64'd1);
      chk("bp_hold_imm", 64'(bus32.out_imm), 64'd1);
      chk("bp_hold_ready", 64'(bus32.in_ready), 64'd0);
    end
    bus32.out_ready = 1'b1;
    idle(1);
    chk("bp_second_valid", 64'(bus32.out_valid), 64'd1);
    chk("bp_second_tag", 64'(bus32.out_tag), 64'd2);
    idle(1);
    bus32.in_valid = 1'b0;
    chk("bp_third_tag", 64'(bus32.out_tag), 64'd3);
    idle(2);

    // Flush with two held and a beat offered
    bus32.out_ready = 1'b0;
    send(32'h01100093, 3'd0, 32'h11);
    send(32'h01200093, 3'd0, 32'h12);
    bus32.in_valid = 1'b1; bus32.in_inst = 32'h09900093; bus32.in_tag = 32'h99;
    flush = 1'b1;
    idle(1);
    flush = 1'b0; bus32.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus32.in_ready), 64'd1);
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("flush_dropped", 64'(bus32.out_valid), 64'd0);
    end

    // Mixed traffic with varying backpressure
    for (int k = 0; k < 8; k++) begin
      bus32.out_ready = (k % 3) != 1;
      send(vec_inst[k], vec_sel[k], 32'h100 + 32'(k));
    end
    bus32.out_ready = 1'b1;
    idle(3);

    // XLEN=64 sign extension
    bus64.in_valid = 1'b1; bus64.in_inst = 32'h800000B7; bus64.in_sel = 3'b010;
    bus64.in_tag = 32'h55;
    idle(1);
    bus64.in_valid = 1'b0;
    chk("x64_U_valid", 64'(bus64.out_valid), 64'd1);
    chk("x64_U_imm", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("x64_U_fmt", 64'(bus64.out_fmt), 64'd2);
    bus64.in_valid = 1'b1; bus64.in_inst = 32'hFE000EE3; bus64.in_sel = 3'b001;
    idle(1);
    bus64.in_valid = 1'b0;
    chk("x64_B_imm", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(2);

    // Asynchronous reset mid-stream
    bus32.out_ready = 1'b0;
    send(32'h02100093, 3'd0, 32'h21);
    send(32'h02200093, 3'd0, 32'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus32.in_ready), 64'd1);
    chk("async_rst_tag", 64'(bus32.out_tag), 64'd0);
    #4 rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    idle(2);
    chk("after_rst_valid", 64'(bus32.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
